// File: rtl/radix4_multiplier.sv
// radix4_multiplier
//   Sequential radix-4 Booth multiplier, one Booth digit retired per clock.
//   Both operands are widened by two bits (sign- or zero-extended) so one
//   datapath serves signed and unsigned products. That gives WIDTH/2+1
//   digits and the same number of EXEC cycles.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   multiplier   operand A, latched on an accepted op_start
//   multiplicand operand B, latched on an accepted op_start
//   op_signed    1 = two's-complement operands, latched with the operands
//   op_start     start request, accepted only in IDLE with op_clear low
//   op_clear     synchronous abort/clear, wins over everything else
//   op_busy      high while in EXEC
//   op_done      high while in DONE
//   result       registered product, zero except in DONE
module radix4_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic               op_signed,
    input  logic               op_start,
    input  logic               op_clear,
    output logic               op_busy,
    output logic               op_done,
    output logic [2*WIDTH-1:0] result
);

    localparam int N_ITER = WIDTH / 2 + 1;
    localparam int EXT_W  = WIDTH + 2;       // extended operand width
    localparam int ACC_W  = EXT_W + 2;       // headroom for +/-2*B plus carry
    localparam int CNT_W  = $clog2(N_ITER + 1);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic signed [EXT_W-1:0] mcand_q;
    logic [EXT_W:0]          mplr_q;         // multiplier with implicit 0 below bit 0
    logic signed [ACC_W-1:0] acc_q;          // high part of the partial product
    logic [EXT_W-1:0]        low_q;          // product bits shifted out of acc_q
    logic [2*WIDTH-1:0]      result_q;

    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] acc_next;
    logic [EXT_W-1:0]        low_next;
    logic [2*WIDTH-1:0]      product;
    logic                    last_iter;

    function automatic logic signed [EXT_W-1:0] extend(input logic [WIDTH-1:0] v,
                                                        input logic s);
        extend = {{2{s & v[WIDTH-1]}}, v};
    endfunction

    // Booth recoding of bits {a[2i+1], a[2i], a[2i-1]} into a multiple of m.
    function automatic logic signed [ACC_W-1:0] booth_pp(input logic [2:0] bits,
                                                          input logic signed [EXT_W-1:0] m);
        logic signed [ACC_W-1:0] m_ext;
        m_ext = {{2{m[EXT_W-1]}}, m};
        case (bits)
            3'b001, 3'b010: booth_pp = m_ext;
            3'b011:         booth_pp = m_ext <<< 1;
            3'b100:         booth_pp = -(m_ext <<< 1);
            3'b101, 3'b110: booth_pp = -m_ext;
            default:        booth_pp = '0;
        endcase
    endfunction

    // Digit datapath: add the digit's multiple, then shift right two places;
    // the two bits leaving acc enter the top of low.
    always_comb begin
        sum       = acc_q + booth_pp(mplr_q[2:0], mcand_q);
        acc_next  = sum >>> 2;
        low_next  = {sum[1:0], low_q[EXT_W-1:2]};
        product   = {acc_next[WIDTH-3:0], low_next};
        last_iter = (cnt_q == CNT_W'(N_ITER - 1));
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear has priority over start.
    always_comb begin
        state_d = state_q;
        if (op_clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (op_start) state_d = ST_EXEC;
                ST_EXEC: if (last_iter) state_d = ST_DONE;
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        op_busy = (state_q == ST_EXEC);
        op_done = (state_q == ST_DONE);
        result  = result_q;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            acc_q    <= '0;
            low_q    <= '0;
            result_q <= '0;
        end else if (op_clear) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            acc_q    <= '0;
            low_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (op_start) begin
                        mcand_q  <= extend(multiplicand, op_signed);
                        mplr_q   <= {extend(multiplier, op_signed), 1'b0};
                        cnt_q    <= '0;
                        acc_q    <= '0;
                        low_q    <= '0;
                        result_q <= '0;
                    end
                end
                ST_EXEC: begin
                    acc_q  <= acc_next;
                    low_q  <= low_next;
                    mplr_q <= {2'b00, mplr_q[EXT_W:2]};
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        result_q <= product;
                    end
                end
                ST_DONE: begin
                    // result held until op_clear
                end
                default: begin
                    // unreachable encoding: leave nothing stale behind
                    cnt_q    <= '0;
                    acc_q    <= '0;
                    low_q    <= '0;
                    result_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_radix4_multiplier.sv
module tb_radix4_multiplier;

    localparam int N32 = 32 / 2 + 1;
    localparam int N8  = 8 / 2 + 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic [31:0] a32 = '0, b32 = '0;
    logic        s32 = 1'b0, start32 = 1'b0, clear32 = 1'b0;
    logic        busy32, done32;
    logic [63:0] res32;

    logic [7:0]  a8 = '0, b8 = '0;
    logic        s8 = 1'b0, start8 = 1'b0, clear8 = 1'b0;
    logic        busy8, done8;
    logic [15:0] res8;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    radix4_multiplier #(.WIDTH(32)) dut32 (
        .clk(clk), .reset_n(reset_n),
        .multiplier(a32), .multiplicand(b32), .op_signed(s32),
        .op_start(start32), .op_clear(clear32),
        .op_busy(busy32), .op_done(done32), .result(res32)
    );

    radix4_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n),
        .multiplier(a8), .multiplicand(b8), .op_signed(s8),
        .op_start(start8), .op_clear(clear8),
        .op_busy(busy8), .op_done(done8), .result(res8)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Exact product of the interpreted operands, truncated to 2*w bits.
    function automatic logic [63:0] exp_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic s, input int w);
        logic signed [127:0] x, y, p;
        logic [63:0] r;
        x = 128'(a);
        y = 128'(b);
        if (s && a[w-1]) x = x - (128'sd1 <<< w);
        if (s && b[w-1]) y = y - (128'sd1 <<< w);
        p = x * y;
        r = p[63:0];
        if (w < 32) r = r & ((64'd1 << (2 * w)) - 64'd1);
        return r;
    endfunction

    // Behavioural model: phase 0 idle, 1 busy, 2 done; product from plain arithmetic.
    int          m32_ph = 0, m32_left = 0;
    logic [63:0] m32_prod = '0;
    int          m8_ph = 0, m8_left = 0;
    logic [63:0] m8_prod = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m32_ph <= 0; m32_left <= 0; m32_prod <= '0;
        end else if (clear32) begin
            m32_ph <= 0; m32_left <= 0; m32_prod <= '0;
        end else if (m32_ph == 0) begin
            if (start32) begin
                m32_ph <= 1; m32_left <= N32; m32_prod <= exp_prod(a32, b32, s32, 32);
            end
        end else if (m32_ph == 1) begin
            m32_left <= m32_left - 1;
            if (m32_left == 1) m32_ph <= 2;
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m8_ph <= 0; m8_left <= 0; m8_prod <= '0;
        end else if (clear8) begin
            m8_ph <= 0; m8_left <= 0; m8_prod <= '0;
        end else if (m8_ph == 0) begin
            if (start8) begin
                m8_ph <= 1; m8_left <= N8; m8_prod <= exp_prod({24'b0, a8}, {24'b0, b8}, s8, 8);
            end
        end else if (m8_ph == 1) begin
            m8_left <= m8_left - 1;
            if (m8_left == 1) m8_ph <= 2;
        end
    end

    // Per-cycle comparison against the model
    always @(posedge clk) begin
        #1;
        check("busy32", {63'b0, busy32}, {63'b0, m32_ph == 1});
        check("done32", {63'b0, done32}, {63'b0, m32_ph == 2});
        check("result32", res32, (m32_ph == 2) ? m32_prod : 64'd0);
        check("busy8", {63'b0, busy8}, {63'b0, m8_ph == 1});
        check("done8", {63'b0, done8}, {63'b0, m8_ph == 2});
        check("result8", {48'b0, res8}, (m8_ph == 2) ? m8_prod : 64'd0);
    end

    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [63:0] exp, input string name);
        int cyc;
        @(negedge clk);
        a32 = a; b32 = b; s32 = s; start32 = 1'b1;
        @(posedge clk);
        #1;
        start32 = 1'b0; a32 = $urandom; b32 = $urandom; s32 = ~s;
        cyc = 0;
        while (!done32 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({name, " latency"}, 64'(cyc), 64'(N32));
        check({name, " result"}, res32, exp);
        @(posedge clk);
        #1;
        check({name, " held"}, res32, exp);
        @(negedge clk);
        clear32 = 1'b1;
        @(posedge clk);
        #1;
        check({name, " cleared"}, {busy32, done32, res32[61:0]}, 64'd0);
        @(negedge clk);
        clear32 = 1'b0;
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [15:0] exp, input string name, input logic hold);
        int cyc;
        @(negedge clk);
        a8 = a; b8 = b; s8 = s; start8 = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        cyc = 0;
        while (!done8 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({name, " latency"}, 64'(cyc), 64'(N8));
        check({name, " result"}, {48'b0, res8}, {48'b0, exp});
        if (hold) begin
            repeat (3) @(posedge clk);
            #1;
            check({name, " no restart"}, {62'b0, busy8, done8}, 64'd1);
            check({name, " held"}, {48'b0, res8}, {48'b0, exp});
        end
        @(negedge clk);
        clear8 = 1'b1;
        @(posedge clk);
        #1;
        check({name, " cleared"}, {46'b0, busy8, done8, res8}, 64'd0);
        @(negedge clk);
        clear8 = 1'b0;
        if (hold) begin
            // start still high: accepted on the first edge back in IDLE
            @(posedge clk);
            #1;
            check({name, " restart"}, {63'b0, busy8}, 64'd1);
            start8 = 1'b0;
            repeat (N8 + 1) @(posedge clk);
            @(negedge clk);
            clear8 = 1'b1;
            @(negedge clk);
            clear8 = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_done;
        #12;
        check("reset32", {busy32, done32, res32[61:0]}, 64'd0);
        check("reset8", {46'b0, busy8, done8, res8}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "u32 max");
        op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h1, "s32 -1*-1");
        op32(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "s32 min*min");
        op32(32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, "s32 -3*5");
        op32(32'd1000, 32'd3, 1'b0, 64'd3000, "u32 1000*3");

        // abort during the 8th EXEC cycle
        @(negedge clk);
        a32 = 32'd123456; b32 = 32'd654321; s32 = 1'b0; start32 = 1'b1;
        @(posedge clk);
        #1;
        start32 = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        clear32 = 1'b1;
        @(posedge clk);
        #1;
        check("abort state", {busy32, done32, res32[61:0]}, 64'd0);
        @(negedge clk);
        clear32 = 1'b0;
        seen_done = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            seen_done = seen_done | done32;
        end
        check("abort no done", {63'b0, seen_done}, 64'd0);
        op32(32'd7, 32'd6, 1'b0, 64'd42, "u32 7*6");

        // start and clear together in IDLE
        @(negedge clk);
        start32 = 1'b1; clear32 = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("start+clear idle", {62'b0, busy32, done32}, 64'd0);
        end
        @(negedge clk);
        start32 = 1'b0; clear32 = 1'b0;

        // async reset: dut32 mid-EXEC, dut8 parked in DONE
        @(negedge clk);
        a8 = 8'h0F; b8 = 8'h0F; s8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (N8) @(posedge clk);
        #1;
        check("park8 result", {48'b0, res8}, 64'd225);
        @(negedge clk);
        a32 = 32'hDEAD_BEEF; b32 = 32'h1234_5678; s32 = 1'b1; start32 = 1'b1;
        @(posedge clk);
        #1;
        start32 = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async rst32", {busy32, done32, res32[61:0]}, 64'd0);
        check("async rst8", {46'b0, busy8, done8, res8}, 64'd0);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        op32(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 64'h0B00_EA4E_242D_2080, "u32 post-reset");

        op8(8'hFF, 8'hFF, 1'b1, 16'h0001, "s8 -1*-1", 1'b0);
        op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u8 255*255", 1'b0);
        op8(8'h80, 8'h7F, 1'b1, 16'hC080, "s8 -128*127", 1'b0);
        op8(8'h0C, 8'h0D, 1'b0, 16'd156, "u8 hold start", 1'b1);

        repeat (2) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
